reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- 16-entry circular reorder buffer for the out-of-order core.
- Accepts up to 4 renamed instructions per cycle from rename/dispatch and records each one's previously mapped physical register.
- Accepts up to 6 completion tags per cycle from the execution units.
- Retires up to 4 completed entries per cycle, in order, and returns their old physical registers to the free list.

Parameters:
- DEPTH, 16, number of entries; power of two; tag width = log2(DEPTH) = 4.
- DISP_W, 4, dispatch and retire width.
- CMPL_W, 6, number of completion ports.
- PREG_W, 6, physical register index width.
- BUNDLE_W, 57, dispatch payload width.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_ins_count  in  3  number of instructions dispatched this cycle, 0..4; slots 0..count-1 are valid.
- i_ins_bundle0..3  in  57 each  dispatch payload; not stored in this revision, port retained for interface stability.
- i_ins_old_p0..3  in  6 each  old physical register of dispatch slot k.
- i_cmpl_en  in  6  per-port completion valid.
- i_cmpl0..5  in  4 each  ROB tag completed on port k.
- o_alloc_id0..3  out  4 each  tag assigned to dispatch slot k; equals (tail+k) mod 16; combinational.
- o_free_count  out  5  free entries, 0..16; registered state.
- o_empty  out  1  occupancy == 0.
- o_ret_count  out  3  entries retired on the last edge, 0..4; registered.
- o_ret_old_p0..3  out  6 each  old physical register of retire slot k; valid for k < o_ret_count; registered.

Behaviour:
State:
- head (4b), tail (4b), occupancy (5b).
- Per entry: valid (1b), done (1b), old_p (6b).
- Output registers: ret_count (3b), ret_old_p0..3 (6b each).

Reset (asynchronous, while i_rst=1):
- head = tail = 0, occupancy = 0.
- All valid and done bits = 0; all old_p = 0.
- o_ret_count = 0, o_ret_old_p0..3 = 0.
- Hence o_free_count = 16, o_empty = 1, o_alloc_id0..3 = 0,1,2,3.
- Reset mid-operation discards all entries immediately; no retirement is reported.

Each rising edge, in this order of precedence:
1. Retire.
   - n = number of leading entries from head with valid&done, capped at 4; stop at the first entry that is not done or not valid.
   - Clear valid and done on those n entries; head += n (mod 16).
   - o_ret_count <= n; o_ret_old_p[k] <= old_p[head+k] for k < n; slots >= n are driven 0.
2. Complete.
   - For each port k with i_cmpl_en[k]=1 and entry i_cmplk currently valid and not being retired: set done.
   - Completions to invalid entries are ignored.
   - Duplicate tags on several ports are harmless.
3. Dispatch.
   - d = i_ins_count.
   - If d > 4, or d > free entries at start of cycle: the whole dispatch is dropped (no partial allocation).
   - Otherwise, for k < d, write entry tail+k with valid=1, done=0, old_p=i_ins_old_pk; tail += d (mod 16).
   - A completion naming an entry being allocated in the same cycle is ignored (dispatch wins, done=0).

Occupancy and timing:
- occupancy <= occupancy − n + d_accepted.
- Slots freed by retirement become visible in o_free_count the next cycle; same-cycle reuse is not allowed.
- Latency: a completion in cycle t sets done at edge t. The entry retires at edge t+1 if all older entries are done. o_ret_* reflect it during cycle t+1→t+2.
- Pointers wrap modulo 16. Full (occupancy 16) and empty (0) are distinguished by occupancy, not by the pointers.

Decomposition:
- Shared package rob_pkg:
  - constants ROB_DEPTH=16, ROB_TAG_W=4, DISP_W=4, CMPL_W=6, PREG_W=6, BUNDLE_W=57.
  - typedefs rob_tag_t, preg_t, rob_entry_t {valid, done, old_p}.
- One natural sub-module, rob_retire_sel: purely combinational leading-done count (0..4) from head, with wrap.

Test Plan:
- Reset: hold i_rst=1 → o_free_count=16, o_empty=1, o_ret_count=0, o_alloc_id0..3=0..3.
- Early completion ignored: dispatch 4 (old_p 10,11,12,13) while i_cmpl_en=6'b101110 with tags 14,3,15,1 in the same cycle → entries 0..3 valid, not done; o_ret_count stays 0; o_free_count=12.
- Out-of-order completion:
  - complete tag 2 alone → o_ret_count remains 0.
  - Then complete tags 0,1 → o_ret_count=3, o_ret_old_p0..2=10,11,12 one cycle later; then complete tag 3 → o_ret_count=1, o_ret_old_p0=13.
- Full and overflow: dispatch 4,4,4,3 → o_free_count=1. Then dispatch 4 → dropped, tail unchanged. Then dispatch 1 → o_free_count=0.
- Wrap-around: fill 16, retire 4 → head=4. Dispatch 4 → o_alloc_id0..3 = 0,1,2,3 (tail wraps). Complete all → retires in order 4..15 then 0..3, 4 per cycle.
- Reset mid-flight: with 10 entries, some done, assert i_rst for one cycle → immediately o_free_count=16, o_ret_count=0; subsequent completions to old tags are ignored.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared constants and types for the reorder buffer slice.
package rob_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_TAG_W = 4;
  localparam int DISP_W    = 4;
  localparam int CMPL_W    = 6;
  localparam int PREG_W    = 6;
  localparam int BUNDLE_W  = 57;
  localparam int OCC_W     = ROB_TAG_W + 1;

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;
  typedef logic [PREG_W-1:0]    preg_t;

  typedef struct packed {
    logic  valid;
    logic  done;
    preg_t old_p;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_retire_sel.sv
// Counts leading valid&done entries starting at head (with wrap), capped at the retire width.
module rob_retire_sel
  import rob_pkg::*;
(
  input  rob_tag_t             head,
  input  logic [ROB_DEPTH-1:0] valid_vec,
  input  logic [ROB_DEPTH-1:0] done_vec,
  output logic [2:0]           ret_count
);

  logic [DISP_W-1:0] ready_s;

  genvar gk;
  for (gk = 0; gk < DISP_W; gk++) begin : g_ready
    assign ready_s[gk] = valid_vec[head + 4'(gk)] & done_vec[head + 4'(gk)];
  end

  // Stop at the first entry that cannot retire.
  always_comb begin
    ret_count = 3'd0;
    if (!ready_s[0]) begin
      ret_count = 3'd0;
    end else if (!ready_s[1]) begin
      ret_count = 3'd1;
    end else if (!ready_s[2]) begin
      ret_count = 3'd2;
    end else if (!ready_s[3]) begin
      ret_count = 3'd3;
    end else begin
      ret_count = 3'd4;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: 4-wide dispatch, 6 completion ports, 4-wide in-order retire.
module reorder_buffer
  import rob_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [2:0]          i_ins_count,
  input  logic [BUNDLE_W-1:0] i_ins_bundle0,
  input  logic [BUNDLE_W-1:0] i_ins_bundle1,
  input  logic [BUNDLE_W-1:0] i_ins_bundle2,
  input  logic [BUNDLE_W-1:0] i_ins_bundle3,
  input  logic [PREG_W-1:0]   i_ins_old_p0,
  input  logic [PREG_W-1:0]   i_ins_old_p1,
  input  logic [PREG_W-1:0]   i_ins_old_p2,
  input  logic [PREG_W-1:0]   i_ins_old_p3,
  input  logic [CMPL_W-1:0]   i_cmpl_en,
  input  logic [ROB_TAG_W-1:0] i_cmpl0,
  input  logic [ROB_TAG_W-1:0] i_cmpl1,
  input  logic [ROB_TAG_W-1:0] i_cmpl2,
  input  logic [ROB_TAG_W-1:0] i_cmpl3,
  input  logic [ROB_TAG_W-1:0] i_cmpl4,
  input  logic [ROB_TAG_W-1:0] i_cmpl5,
  output logic [ROB_TAG_W-1:0] o_alloc_id0,
  output logic [ROB_TAG_W-1:0] o_alloc_id1,
  output logic [ROB_TAG_W-1:0] o_alloc_id2,
  output logic [ROB_TAG_W-1:0] o_alloc_id3,
  output logic [OCC_W-1:0]    o_free_count,
  output logic                o_empty,
  output logic [2:0]          o_ret_count,
  output logic [PREG_W-1:0]   o_ret_old_p0,
  output logic [PREG_W-1:0]   o_ret_old_p1,
  output logic [PREG_W-1:0]   o_ret_old_p2,
  output logic [PREG_W-1:0]   o_ret_old_p3
);

  rob_entry_t           entries_r     [ROB_DEPTH];
  rob_entry_t           entries_nxt_s [ROB_DEPTH];
  rob_tag_t             head_r, tail_r;
  logic [OCC_W-1:0]     occ_r, free_s;
  logic [2:0]           ret_count_r, ret_n_s;
  preg_t                ret_old_p_r   [DISP_W];
  preg_t                ret_old_p_nxt_s [DISP_W];
  preg_t                ins_old_p_s   [DISP_W];
  rob_tag_t             cmpl_tag_s    [CMPL_W];
  logic [ROB_DEPTH-1:0] valid_vec_s, done_vec_s, ret_mask_s, alloc_mask_s, cmpl_hit_s;
  preg_t                alloc_p_s     [ROB_DEPTH];
  logic                 disp_ok_s;
  logic                 bundle_unused_s;

  // Payload is carried on the interface only.
  assign bundle_unused_s = ^{i_ins_bundle0, i_ins_bundle1, i_ins_bundle2, i_ins_bundle3};

  assign ins_old_p_s = '{i_ins_old_p0, i_ins_old_p1, i_ins_old_p2, i_ins_old_p3};
  assign cmpl_tag_s  = '{i_cmpl0, i_cmpl1, i_cmpl2, i_cmpl3, i_cmpl4, i_cmpl5};

  assign free_s       = 5'(ROB_DEPTH) - occ_r;
  assign o_free_count = free_s;
  assign o_empty      = (occ_r == 5'd0);
  assign o_alloc_id0  = tail_r;
  assign o_alloc_id1  = tail_r + 4'd1;
  assign o_alloc_id2  = tail_r + 4'd2;
  assign o_alloc_id3  = tail_r + 4'd3;
  assign o_ret_count  = ret_count_r;
  assign o_ret_old_p0 = ret_old_p_r[0];
  assign o_ret_old_p1 = ret_old_p_r[1];
  assign o_ret_old_p2 = ret_old_p_r[2];
  assign o_ret_old_p3 = ret_old_p_r[3];

  // All-or-nothing dispatch, judged against free space at the start of the cycle.
  assign disp_ok_s = (i_ins_count <= 3'd4) && ({2'b00, i_ins_count} <= free_s);

  rob_retire_sel u_retire_sel (
    .head      (head_r),
    .valid_vec (valid_vec_s),
    .done_vec  (done_vec_s),
    .ret_count (ret_n_s)
  );

  genvar gi;
  for (gi = 0; gi < ROB_DEPTH; gi++) begin : g_ent
    assign valid_vec_s[gi]  = entries_r[gi].valid;
    assign done_vec_s[gi]   = entries_r[gi].done;
    assign ret_mask_s[gi]   = (4'(gi) - head_r) < {1'b0, ret_n_s};
    assign alloc_mask_s[gi] = disp_ok_s & ((4'(gi) - tail_r) < {1'b0, i_ins_count});
    assign alloc_p_s[gi]    = ins_old_p_s[2'(4'(gi) - tail_r)];
  end

  for (gi = 0; gi < DISP_W; gi++) begin : g_ret
    assign ret_old_p_nxt_s[gi] = (3'(gi) < ret_n_s) ? entries_r[head_r + 4'(gi)].old_p : '0;
  end

  // Per-entry hit from any enabled completion port.
  always_comb begin
    cmpl_hit_s = '0;
    for (int i = 0; i < ROB_DEPTH; i++) begin
      for (int k = 0; k < CMPL_W; k++) begin
        cmpl_hit_s[i] = cmpl_hit_s[i] | (i_cmpl_en[k] & (cmpl_tag_s[k] == 4'(i)));
      end
    end
  end

  // Entry update: allocation beats retirement beats completion.
  always_comb begin
    for (int i = 0; i < ROB_DEPTH; i++) begin
      entries_nxt_s[i] = entries_r[i];
      if (alloc_mask_s[i]) begin
        entries_nxt_s[i] = '{valid: 1'b1, done: 1'b0, old_p: alloc_p_s[i]};
      end else if (ret_mask_s[i]) begin
        entries_nxt_s[i].valid = 1'b0;
        entries_nxt_s[i].done  = 1'b0;
      end else if (cmpl_hit_s[i] && entries_r[i].valid) begin
        entries_nxt_s[i].done = 1'b1;
      end else begin
        entries_nxt_s[i] = entries_r[i];
      end
    end
  end

  // State and retire output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head_r      <= 4'd0;
      tail_r      <= 4'd0;
      occ_r       <= 5'd0;
      ret_count_r <= 3'd0;
      for (int i = 0; i < ROB_DEPTH; i++) entries_r[i] <= '0;
      for (int k = 0; k < DISP_W; k++) ret_old_p_r[k] <= '0;
    end else begin
      head_r      <= head_r + {1'b0, ret_n_s};
      tail_r      <= tail_r + (disp_ok_s ? {1'b0, i_ins_count} : 4'd0);
      occ_r       <= occ_r - {2'b00, ret_n_s} + (disp_ok_s ? {2'b00, i_ins_count} : 5'd0);
      ret_count_r <= ret_n_s;
      entries_r   <= entries_nxt_s;
      ret_old_p_r <= ret_old_p_nxt_s;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus random traffic against a queue model.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  ins_count = 3'd0;
  logic [56:0] bundle [4];
  logic [5:0]  old_p [4];
  logic [5:0]  cmpl_en = 6'd0;
  logic [3:0]  cmpl [6];
  logic [3:0]  alloc_id [4];
  logic [4:0]  free_count;
  logic        empty;
  logic [2:0]  ret_count;
  logic [5:0]  ret_p [4];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int tag;
    int old_p;
    bit done;
  } m_ent_t;

  m_ent_t mq[$];
  int     m_tail = 0;
  int     m_ret_cnt = 0;
  int     m_ret_p [4];

  always #5 clk = ~clk;

  reorder_buffer dut (
    .i_clk(clk), .i_rst(rst), .i_ins_count(ins_count),
    .i_ins_bundle0(bundle[0]), .i_ins_bundle1(bundle[1]),
    .i_ins_bundle2(bundle[2]), .i_ins_bundle3(bundle[3]),
    .i_ins_old_p0(old_p[0]), .i_ins_old_p1(old_p[1]),
    .i_ins_old_p2(old_p[2]), .i_ins_old_p3(old_p[3]),
    .i_cmpl_en(cmpl_en),
    .i_cmpl0(cmpl[0]), .i_cmpl1(cmpl[1]), .i_cmpl2(cmpl[2]),
    .i_cmpl3(cmpl[3]), .i_cmpl4(cmpl[4]), .i_cmpl5(cmpl[5]),
    .o_alloc_id0(alloc_id[0]), .o_alloc_id1(alloc_id[1]),
    .o_alloc_id2(alloc_id[2]), .o_alloc_id3(alloc_id[3]),
    .o_free_count(free_count), .o_empty(empty), .o_ret_count(ret_count),
    .o_ret_old_p0(ret_p[0]), .o_ret_old_p1(ret_p[1]),
    .o_ret_old_p2(ret_p[2]), .o_ret_old_p3(ret_p[3])
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_tail = 0;
    m_ret_cnt = 0;
    for (int k = 0; k < 4; k++) m_ret_p[k] = 0;
  endtask

  // One clock edge of reorder-buffer behaviour: retire, then complete, then dispatch.
  task automatic model_step();
    int start_size = mq.size();
    m_ret_cnt = 0;
    for (int k = 0; k < 4; k++) m_ret_p[k] = 0;
    while (mq.size() > 0 && mq[0].done && m_ret_cnt < 4) begin
      m_ret_p[m_ret_cnt] = mq[0].old_p;
      m_ret_cnt++;
      void'(mq.pop_front());
    end
    for (int p = 0; p < 6; p++) begin
      if (cmpl_en[p]) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (mq[i].tag == int'(cmpl[p])) mq[i].done = 1'b1;
        end
      end
    end
    if (int'(ins_count) <= 4 && int'(ins_count) <= 16 - start_size) begin
      for (int k = 0; k < int'(ins_count); k++) begin
        m_ent_t e;
        e.tag = (m_tail + k) % 16;
        e.old_p = int'(old_p[k]);
        e.done = 1'b0;
        mq.push_back(e);
      end
      m_tail = (m_tail + int'(ins_count)) % 16;
    end
  endtask

  task automatic check_outputs();
    check("free_count", int'(free_count), 16 - mq.size());
    check("empty", int'(empty), (mq.size() == 0) ? 1 : 0);
    check("ret_count", int'(ret_count), m_ret_cnt);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("ret_old_p%0d", k), int'(ret_p[k]), m_ret_p[k]);
      check($sformatf("alloc_id%0d", k), int'(alloc_id[k]), (m_tail + k) % 16);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    ins_count = 3'd0;
    cmpl_en = 6'd0;
  endtask

  task automatic set_disp(input int cnt, input int base);
    ins_count = 3'(cnt);
    for (int k = 0; k < 4; k++) begin
      old_p[k] = 6'(base + k);
      bundle[k] = {25'd0, $urandom()};
    end
  endtask

  task automatic complete(input int t0, input int t1, input int t2, input int n);
    int t [3];
    t = '{t0, t1, t2};
    cmpl_en = 6'd0;
    for (int p = 0; p < n; p++) begin
      cmpl_en[p] = 1'b1;
      cmpl[p] = 4'(t[p]);
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      old_p[k] = 6'd0;
      bundle[k] = 57'd0;
    end
    for (int p = 0; p < 6; p++) cmpl[p] = 4'd0;
    model_reset();

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_free", int'(free_count), 16);
    check("rst_empty", int'(empty), 1);
    check("rst_ret_count", int'(ret_count), 0);
    for (int k = 0; k < 4; k++) check($sformatf("rst_alloc%0d", k), int'(alloc_id[k]), k);
    rst = 1'b0;

    // Completions naming entries allocated in the same cycle are ignored
    set_disp(4, 10);
    cmpl_en = 6'b101110;
    cmpl[1] = 4'd14; cmpl[2] = 4'd3; cmpl[3] = 4'd15; cmpl[5] = 4'd1;
    cycle();
    idle_inputs();
    cycle();
    check("early_free", int'(free_count), 12);
    check("early_ret", int'(ret_count), 0);

    // Out-of-order completion
    complete(2, 0, 0, 1);
    cycle();
    idle_inputs();
    cycle();
    check("ooo_hold", int'(ret_count), 0);
    complete(0, 1, 0, 2);
    cycle();
    idle_inputs();
    cycle();
    check("ooo_ret3", int'(ret_count), 3);
    check("ooo_p0", int'(ret_p[0]), 10);
    check("ooo_p1", int'(ret_p[1]), 11);
    check("ooo_p2", int'(ret_p[2]), 12);
    complete(3, 0, 0, 1);
    cycle();
    idle_inputs();
    cycle();
    check("ooo_ret1", int'(ret_count), 1);
    check("ooo_p3", int'(ret_p[0]), 13);

    // Fill to 15, overflowing dispatch is dropped, then fill the last slot
    for (int b = 0; b < 3; b++) begin
      set_disp(4, 20 + 4 * b);
      cycle();
    end
    set_disp(3, 40);
    cycle();
    check("fill_free1", int'(free_count), 1);
    set_disp(4, 50);
    cycle();
    check("overflow_free", int'(free_count), 1);
    check("overflow_tail", int'(alloc_id[0]), 3);
    set_disp(1, 60);
    cycle();
    check("full_free", int'(free_count), 0);
    idle_inputs();

    // Retire four from head 4, then dispatch across the wrap
    complete(4, 5, 6, 3);
    cycle();
    complete(7, 7, 7, 3);
    cycle();
    idle_inputs();
    cycle();
    check("wrap_free", int'(free_count), 4);
    set_disp(4, 30);
    cycle();
    idle_inputs();
    for (int c = 0; c < 6; c++) begin
      complete((c * 3 + 8) % 16, (c * 3 + 9) % 16, (c * 3 + 10) % 16, 3);
      cycle();
    end
    idle_inputs();
    repeat (6) cycle();
    check("wrap_drained", int'(empty), 1);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      set_disp($urandom_range(7), $urandom_range(63));
      cmpl_en = 6'($urandom());
      for (int p = 0; p < 6; p++) cmpl[p] = 4'($urandom_range(15));
      cycle();
    end

    // Asynchronous reset mid-flight
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      set_disp(3, 8 * c);
      complete((m_tail + 15) % 16, (m_tail + 14) % 16, 0, 2);
      cycle();
    end
    rst = 1'b1;
    #1;
    model_reset();
    check("midrst_free", int'(free_count), 16);
    check("midrst_ret", int'(ret_count), 0);
    check_outputs();
    idle_inputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
    complete(0, 1, 2, 3);
    cycle();
    idle_inputs();
    cycle();
    check("post_rst_ret", int'(ret_count), 0);

    // Random traffic after reset
    for (int c = 0; c < 200; c++) begin
      set_disp($urandom_range(5), $urandom_range(63));
      cmpl_en = 6'($urandom());
      for (int p = 0; p < 6; p++) cmpl[p] = 4'($urandom_range(15));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
